csr_trap_sequencer: RTL and testbench

Machine-mode trap/return controller that owns the single write port of the CSR register file.
- Arbitrates between pipeline CSR instructions and trap entry / MRET.
- Sequences the multi-register updates: mepc, mcause, mtval, mstatus, then reads mtvec or mepc.
- Issues a one-cycle PC redirect to the fetch stage.

---
 rtl/csr_trap_sequencer.sv | 111 +++++++++++
 tb/tb_csr_trap_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: machine-mode trap entry / MRET sequencer that owns the CSR write port
module csr_trap_sequencer #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_epc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic              mret_req,
  output logic              trap_ack,
  output logic              mret_ack,
  input  logic              csr_inst_valid,
  input  logic [CSR_AW-1:0] csr_inst_addr,
  input  logic [XLEN-1:0]   csr_inst_wdata,
  input  logic              csr_inst_wen,
  output logic              csr_inst_ready,
  output logic [XLEN-1:0]   csr_inst_rdata,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_w_data,
  output logic              csr_w_en,
  input  logic [XLEN-1:0]   csr_r_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, R_STATUS, R_EPC} state_t;
  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);
  localparam logic [XLEN-1:0]   ALIGN     = ~XLEN'(3);
  state_t state, state_nx;
  logic [XLEN-1:0] cause_q, epc_q, tval_q, r_base, vec_pc, st_trap, st_mret;
  logic take_trap, take_mret, pass;
  // Acceptance decisions: trap beats MRET beats the pipeline; nothing is granted while in reset
  assign take_trap = reset_n && state == IDLE && trap_req;
  assign take_mret = reset_n && state == IDLE && !trap_req && mret_req;
  assign pass      = reset_n && state == IDLE && !trap_req && !mret_req;
  assign trap_ack  = take_trap;
  assign mret_ack  = take_mret;
  assign busy      = state != IDLE;
  assign r_base    = csr_r_data & ALIGN;
  assign vec_pc    = (csr_r_data[1:0] == 2'b01 && cause_q[XLEN-1]) ? r_base + {cause_q[XLEN-3:0], 2'b00} : r_base;
  // mstatus read-modify-write images for trap entry and MRET
  always_comb begin
    st_trap = csr_r_data;
    st_trap[7] = csr_r_data[3];
    st_trap[3] = 1'b0;
    st_trap[12:11] = 2'b11;
    st_mret = csr_r_data;
    st_mret[3] = csr_r_data[7];
    st_mret[7] = 1'b1;
    st_mret[12:11] = 2'b11;
  end
  // State register, latched trap operands and the registered redirect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_nx;
      if (take_trap) begin
        cause_q <= trap_cause;
        epc_q <= trap_epc;
        tval_q <= trap_tval;
      end
      redirect_valid <= state == T_VEC || state == R_EPC;
      if (state == T_VEC) redirect_pc <= vec_pc;
      else if (state == R_EPC) redirect_pc <= r_base;
    end
  end
  // Next-state: fixed walk through the trap or MRET register sequence
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = take_trap ? T_EPC : take_mret ? R_STATUS : IDLE;
      T_EPC:    state_nx = T_CAUSE;
      T_CAUSE:  state_nx = T_TVAL;
      T_TVAL:   state_nx = T_STATUS;
      T_STATUS: state_nx = T_VEC;
      R_STATUS: state_nx = R_EPC;
      default:  state_nx = IDLE;
    endcase
  end
  // Outputs: pipeline pass-through when idle, otherwise the sequencer drives the CSR port
  always_comb begin
    csr_inst_ready = pass;
    csr_inst_rdata = pass ? csr_r_data : '0;
    csr_addr = pass ? csr_inst_addr : '0;
    csr_w_data = pass ? csr_inst_wdata : '0;
    csr_w_en = pass && csr_inst_valid && csr_inst_wen;
    case (state)
      T_EPC:    begin csr_addr = A_MEPC;    csr_w_data = epc_q & ALIGN; csr_w_en = 1'b1; end
      T_CAUSE:  begin csr_addr = A_MCAUSE;  csr_w_data = cause_q;       csr_w_en = 1'b1; end
      T_TVAL:   begin csr_addr = A_MTVAL;   csr_w_data = tval_q;        csr_w_en = 1'b1; end
      T_STATUS: begin csr_addr = A_MSTATUS; csr_w_data = st_trap;       csr_w_en = 1'b1; end
      T_VEC:    csr_addr = A_MTVEC;
      R_STATUS: begin csr_addr = A_MSTATUS; csr_w_data = st_mret;       csr_w_en = 1'b1; end
      R_EPC:    csr_addr = A_MEPC;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: scoreboard bench for the CSR trap/MRET sequencer with a behavioural regfile
module tb_csr_trap_sequencer;
  logic clock = 1'b0, clk_en = 1'b0, reset_n = 1'b0;
  logic trap_req = 0, mret_req = 0, csr_inst_valid = 0, csr_inst_wen = 0;
  logic [31:0] trap_cause = 0, trap_epc = 0, trap_tval = 0, csr_inst_wdata = 0;
  logic [11:0] csr_inst_addr = 0;
  logic trap_ack, mret_ack, csr_inst_ready, csr_w_en, redirect_valid, busy;
  logic [31:0] csr_inst_rdata, csr_w_data, csr_r_data, redirect_pc;
  logic [11:0] csr_addr;
  logic [31:0] rf [0:4095];
  typedef struct packed {logic [11:0] a; logic [31:0] d;} wr_t;
  wr_t wr_q[$];
  int passed = 0, total = 0;

  csr_trap_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .mret_req(mret_req), .trap_ack(trap_ack), .mret_ack(mret_ack),
    .csr_inst_valid(csr_inst_valid), .csr_inst_addr(csr_inst_addr), .csr_inst_wdata(csr_inst_wdata),
    .csr_inst_wen(csr_inst_wen), .csr_inst_ready(csr_inst_ready), .csr_inst_rdata(csr_inst_rdata),
    .csr_addr(csr_addr), .csr_w_data(csr_w_data), .csr_w_en(csr_w_en), .csr_r_data(csr_r_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 if (clk_en) clock = ~clock;
  assign csr_r_data = rf[csr_addr];
  always @(posedge clock) if (csr_w_en) rf[csr_addr] <= csr_w_data;

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_inst_valid = 1; csr_inst_wen = 1; csr_inst_addr = a; csr_inst_wdata = d;
    nxt;
    csr_inst_valid = 0; csr_inst_wen = 0;
  endtask

  task automatic pop_write(input string name);
    wr_t e;
    total++;
    if (wr_q.size() == 0) $display("FAIL %s unexpected write: got %h=%h want none", name, csr_addr, csr_w_data);
    else begin
      e = wr_q.pop_front();
      if ({csr_addr, csr_w_data} !== e) $display("FAIL %s write: got %h=%h want %h=%h", name, csr_addr, csr_w_data, e.a, e.d);
      else passed++;
    end
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({trap_ack, mret_ack, redirect_valid, csr_w_en, busy, csr_inst_ready} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {trap_ack, mret_ack, redirect_valid, csr_w_en, busy, csr_inst_ready});
    else passed++;
    total++;
    if (redirect_pc !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", redirect_pc); else passed++;
    clk_en = 1;
    nxt;
    reset_n = 1;
    csr_inst_valid = 1; csr_inst_wen = 1; csr_inst_addr = 12'h340; csr_inst_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if ({csr_inst_ready, csr_w_en, csr_addr, csr_w_data} !== {2'b11, 12'h340, 32'hDEADBEEF})
      $display("FAIL pass_write: got %b%b %h=%h want 11 340=deadbeef", csr_inst_ready, csr_w_en, csr_addr, csr_w_data);
    else passed++;
    nxt;
    csr_inst_wen = 0;
    #1;
    total++;
    if ({csr_w_en, csr_inst_rdata} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL pass_read: got %b %h want 0 deadbeef", csr_w_en, csr_inst_rdata);
    else passed++;
    csr_inst_valid = 0;
    nxt;
  endtask

  task automatic test_trap(input string name, input logic [31:0] mtvec, mstatus, cause, epc, tval, exp_st, exp_pc);
    int got = -1;
    csr_wr(12'h305, mtvec);
    csr_wr(12'h300, mstatus);
    trap_req = 1; trap_cause = cause; trap_epc = epc; trap_tval = tval;
    wr_q.push_back({12'h341, epc & ~32'h3});
    wr_q.push_back({12'h342, cause});
    wr_q.push_back({12'h343, tval});
    wr_q.push_back({12'h300, exp_st});
    #1;
    total++;
    if ({trap_ack, csr_inst_ready, csr_w_en} !== 3'b100)
      $display("FAIL %s ack: got %b want 100", name, {trap_ack, csr_inst_ready, csr_w_en});
    else passed++;
    for (int c = 1; c <= 12 && got < 0; c++) begin
      nxt;
      trap_req = 0;
      #1;
      if (csr_w_en) pop_write(name);
      if (redirect_valid) got = c;
    end
    total++;
    if (got != 6) $display("FAIL %s latency: got %0d want 6", name, got); else passed++;
    total++;
    if (redirect_pc !== exp_pc) $display("FAIL %s pc: got %h want %h", name, redirect_pc, exp_pc); else passed++;
    total++;
    if (wr_q.size() != 0) $display("FAIL %s missing writes: got %0d left want 0", name, wr_q.size()); else passed++;
    wr_q.delete();
    nxt;
    total++;
    if ({redirect_valid, redirect_pc} !== {1'b0, exp_pc})
      $display("FAIL %s pulse: got %b %h want 0 %h", name, redirect_valid, redirect_pc, exp_pc);
    else passed++;
  endtask

  task automatic test_mret(input string name, input logic [31:0] mstatus, mepc, exp_st, exp_pc);
    int got = -1;
    csr_wr(12'h300, mstatus);
    csr_wr(12'h341, mepc);
    mret_req = 1;
    wr_q.push_back({12'h300, exp_st});
    #1;
    total++;
    if ({mret_ack, trap_ack, csr_inst_ready} !== 3'b100)
      $display("FAIL %s ack: got %b want 100", name, {mret_ack, trap_ack, csr_inst_ready});
    else passed++;
    for (int c = 1; c <= 8 && got < 0; c++) begin
      nxt;
      mret_req = 0;
      #1;
      if (csr_w_en) pop_write(name);
      if (redirect_valid) got = c;
    end
    total++;
    if (got != 3) $display("FAIL %s latency: got %0d want 3", name, got); else passed++;
    total++;
    if (redirect_pc !== exp_pc) $display("FAIL %s pc: got %h want %h", name, redirect_pc, exp_pc); else passed++;
    total++;
    if (wr_q.size() != 0) $display("FAIL %s missing writes: got %0d left want 0", name, wr_q.size()); else passed++;
    wr_q.delete();
    nxt;
  endtask

  task automatic test_back_to_back;
    int r1 = -1, r2 = -1, ma = -1, rd = -1, bad = 0;
    logic [31:0] pc1 = 0;
    csr_wr(12'h305, 32'h300);
    csr_wr(12'h300, 32'h0);
    trap_req = 1; mret_req = 1; trap_cause = 3; trap_epc = 32'h4000; trap_tval = 1;
    csr_inst_valid = 1; csr_inst_wen = 1; csr_inst_addr = 12'h340; csr_inst_wdata = 32'h55;
    wr_q.push_back({12'h341, 32'h4000});
    wr_q.push_back({12'h342, 32'h3});
    wr_q.push_back({12'h343, 32'h1});
    wr_q.push_back({12'h300, 32'h1800});
    wr_q.push_back({12'h300, 32'h1880});
    wr_q.push_back({12'h340, 32'h55});
    #1;
    total++;
    if ({trap_ack, mret_ack, csr_inst_ready} !== 3'b100)
      $display("FAIL b2b first: got %b want 100", {trap_ack, mret_ack, csr_inst_ready});
    else passed++;
    for (int c = 1; c <= 20 && rd < 0; c++) begin
      nxt;
      trap_req = 0;
      if (ma > 0) mret_req = 0;
      #1;
      if (csr_w_en) pop_write("b2b");
      if (mret_ack && ma < 0) ma = c;
      if (redirect_valid && r1 < 0) begin r1 = c; pc1 = redirect_pc; end
      else if (redirect_valid) r2 = c;
      if (csr_inst_ready) rd = c;
      if (c != 6 && c < 9 && !busy) bad++;
    end
    csr_inst_valid = 0; csr_inst_wen = 0;
    total++;
    if ({ma, r1} !== {32'd6, 32'd6}) $display("FAIL b2b mret_ack: got ack %0d redirect %0d want 6 6", ma, r1); else passed++;
    total++;
    if (pc1 !== 32'h300) $display("FAIL b2b trap_pc: got %h want 00000300", pc1); else passed++;
    total++;
    if ({r2, rd} !== {32'd9, 32'd9}) $display("FAIL b2b mret_done: got redirect %0d grant %0d want 9 9", r2, rd); else passed++;
    total++;
    if (redirect_pc !== 32'h4000) $display("FAIL b2b mret_pc: got %h want 00004000", redirect_pc); else passed++;
    total++;
    if (bad != 0) $display("FAIL b2b busy: got %0d idle cycles want 0", bad); else passed++;
    total++;
    if (wr_q.size() != 0) $display("FAIL b2b missing writes: got %0d left want 0", wr_q.size()); else passed++;
    wr_q.delete();
    nxt;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    csr_wr(12'h342, 32'hAAAA5555);
    csr_wr(12'h341, 32'h0);
    trap_req = 1; trap_cause = 32'hB; trap_epc = 32'h8008; trap_tval = 0;
    nxt;
    trap_req = 0;
    nxt;
    #1;
    total++;
    if ({csr_w_en, csr_addr} !== {1'b1, 12'h342}) $display("FAIL abort in_cause: got %b %h want 1 342", csr_w_en, csr_addr); else passed++;
    reset_n = 0;
    #1;
    total++;
    if ({busy, csr_w_en, redirect_valid} !== 3'b000) $display("FAIL abort idle: got %b want 000", {busy, csr_w_en, redirect_valid}); else passed++;
    nxt;
    reset_n = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (redirect_valid || busy) seen++;
      nxt;
    end
    total++;
    if (seen != 0) $display("FAIL abort redirect: got %0d active cycles want 0", seen); else passed++;
    total++;
    if (rf[12'h341] !== 32'h8008) $display("FAIL abort mepc: got %h want 00008008", rf[12'h341]); else passed++;
    total++;
    if (rf[12'h342] !== 32'hAAAA5555) $display("FAIL abort mcause: got %h want aaaa5555", rf[12'h342]); else passed++;
  endtask

  initial begin
    test_reset;
    test_trap("direct", 32'h100, 32'h8, 32'h2, 32'h1006, 32'h13, 32'h1880, 32'h100);
    test_trap("vec_irq", 32'h201, 32'h8, 32'h80000007, 32'h2000, 32'h0, 32'h1880, 32'h21C);
    test_trap("vec_exc", 32'h201, 32'h0, 32'h7, 32'h2002, 32'h44, 32'h1800, 32'h200);
    test_mret("mret", 32'h1880, 32'h1004, 32'h1888, 32'h1004);
    test_mret("mret_lo", 32'h0, 32'h2003, 32'h1880, 32'h2000);
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
